clk_div_ctrl: RTL and testbench

Programmable even-ratio clock divider controller. It generates a 50%-duty divided signal of period 2×H input clocks, where H is a half-period loaded over a valid/ready configuration port. The controller sequences start, stop and ratio changes so that every period completes whole: no runt pulses and no mid-period ratio switch. It sits beside the fixed divide-by-4 dividers and replaces them wherever the ratio must change at run time.

---
 rtl/clk_div_ctrl.sv | 128 ++++++++++++
 tb/tb_clk_div_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable even-ratio (2*H) clock divider that only changes ratio, starts or stops on whole-period boundaries.
// Optional macro DIV_ERR_CHECK_EN: reject zero half-period configurations and pulse cfg_err.
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             div_out,
  output logic             rise_tick,
  output logic             busy,
  output logic [CNT_W-1:0] active_half,
  output logic             cfg_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_valid;
  logic             r_rise;

  logic             w_accept;
  logic             w_take;
  logic             w_last;
  logic             w_go;
  logic [CNT_W-1:0] w_eff;

  assign cfg_ready = !r_pend_valid;
  assign w_accept  = cfg_valid && cfg_ready;

`ifdef DIV_ERR_CHECK_EN
  logic r_err;

  // A zero half-period completes the handshake but is dropped and flagged.
  assign w_take = w_accept && (cfg_half != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && (cfg_half == '0);
    end
  end

  assign cfg_err = r_err;
`else
  assign w_take  = w_accept;
  assign cfg_err = 1'b0;
`endif

  // Half-period that would govern the next phase if a boundary happened now.
  assign w_eff  = w_take ? cfg_half : (r_pend_valid ? r_pend : r_active);
  assign w_last = (r_cnt == r_active - CNT_W'(1));
  assign w_go   = en && (w_eff != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_active     <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_rise       <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_active <= w_eff;
          if (w_go) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_rise  <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_take) begin
            r_pend       <= cfg_half;
            r_pend_valid <= 1'b1;
          end
          if (w_last) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LOW: begin
          // The LOW terminal edge is the only point where ratio, run and stop decisions land.
          if (w_last) begin
            r_active     <= w_eff;
            r_pend_valid <= 1'b0;
            r_cnt        <= '0;
            if (w_go) begin
              r_state <= S_HIGH;
              r_rise  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_take) begin
              r_pend       <= cfg_half;
              r_pend_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign div_out     = (r_state == S_HIGH);
  assign busy        = (r_state != S_IDLE);
  assign rise_tick   = r_rise;
  assign active_half = r_active;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model predicts every cycle's outputs.
// Honours DIV_ERR_CHECK_EN the same way the design does.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;
`ifdef DIV_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             div_out;
  logic             rise_tick;
  logic             busy;
  logic [CNT_W-1:0] active_half;
  logic             cfg_err;

  typedef struct {
    logic             div;
    logic             rise;
    logic             busy;
    logic             ready;
    logic             err;
    logic [CNT_W-1:0] ah;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycle      = 0;

  clk_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_ready   (cfg_ready),
    .div_out     (div_out),
    .rise_tick   (rise_tick),
    .busy        (busy),
    .active_half (active_half),
    .cfg_err     (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tracks position within the whole 2H period rather than HIGH/LOW phases.
  initial begin : model
    bit running;
    int h;
    int pos;
    int pendQ[$];
    bit rise;
    bit err;
    bit ready;
    bit accepted;
    bit take;
    exp_t e;
    running = 0;
    h = 0;
    pos = 0;
    forever begin
      @(posedge clk);
      rise = 0;
      err  = 0;
      if (reset) begin
        running = 0;
        h = 0;
        pos = 0;
        pendQ.delete();
      end else begin
        ready    = (pendQ.size() == 0);
        accepted = cfg_valid && ready;
        take     = accepted && !(ERR_EN && cfg_half == 0);
        err      = accepted && ERR_EN && (cfg_half == 0);
        if (!running) begin
          if (take) h = int'(cfg_half);
          if (en && h != 0) begin
            running = 1;
            pos = 0;
            rise = 1;
          end
        end else if (pos != 2 * h - 1) begin
          pos++;
          if (take) pendQ.push_back(int'(cfg_half));
        end else begin
          if (take) h = int'(cfg_half);
          else if (pendQ.size() != 0) h = pendQ[0];
          pendQ.delete();
          if (en && h != 0) begin
            pos = 0;
            rise = 1;
          end else begin
            running = 0;
          end
        end
      end
      e.div   = running && (pos < h);
      e.rise  = rise;
      e.busy  = running;
      e.ready = (pendQ.size() == 0);
      e.err   = err;
      e.ah    = CNT_W'(h);
      expQ.push_back(e);
    end
  end

  task automatic checkOutput(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] expv);
    checkCount++;
    if (act !== expv)
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, expv);
    else
      passCount++;
  endtask

  // Monitor: the DUT presents a full output set every cycle, so pop one expectation per edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cycle);
      end else begin
        e = expQ.pop_front();
        checkOutput("div_out",     CNT_W'(div_out),   CNT_W'(e.div));
        checkOutput("rise_tick",   CNT_W'(rise_tick), CNT_W'(e.rise));
        checkOutput("busy",        CNT_W'(busy),      CNT_W'(e.busy));
        checkOutput("cfg_ready",   CNT_W'(cfg_ready), CNT_W'(e.ready));
        checkOutput("cfg_err",     CNT_W'(cfg_err),   CNT_W'(e.err));
        checkOutput("active_half", active_half,       e.ah);
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [CNT_W-1:0] h, input int n);
    for (int i = 0; i < n; i++) begin
      reset     = r;
      en        = e;
      cfg_valid = v;
      cfg_half  = h;
      @(negedge clk);
    end
  endtask

  initial begin : stimulus
    bit rr;
    bit ee;
    bit vv;
    logic [CNT_W-1:0] hh;
    applyStimulus(1, 0, 0, 8'd0, 2);
    // Basic run at H=2, then minimum ratio H=1
    applyStimulus(0, 0, 1, 8'd2, 1);
    applyStimulus(0, 1, 0, 8'd0, 12);
    applyStimulus(1, 0, 0, 8'd0, 1);
    applyStimulus(0, 1, 1, 8'd1, 1);
    applyStimulus(0, 1, 0, 8'd0, 8);
    // Ratio change mid-HIGH at H=3 plus a stalled second offer
    applyStimulus(1, 0, 0, 8'd0, 1);
    applyStimulus(0, 1, 1, 8'd3, 1);
    applyStimulus(0, 1, 0, 8'd0, 1);
    applyStimulus(0, 1, 1, 8'd5, 1);
    applyStimulus(0, 1, 1, 8'd7, 10);
    applyStimulus(0, 1, 0, 8'd0, 30);
    // Boundary bypass: offer H=4 at each offset of an H=2 period
    for (int off = 0; off < 4; off++) begin
      applyStimulus(1, 0, 0, 8'd0, 1);
      applyStimulus(0, 1, 1, 8'd2, 1);
      applyStimulus(0, 1, 0, 8'd0, off + 4);
      applyStimulus(0, 1, 1, 8'd4, 1);
      applyStimulus(0, 1, 0, 8'd0, 12);
    end
    // Stop in the 2nd HIGH cycle at H=3, then reset mid-LOW
    applyStimulus(1, 0, 0, 8'd0, 1);
    applyStimulus(0, 1, 1, 8'd3, 2);
    applyStimulus(0, 0, 0, 8'd0, 8);
    applyStimulus(0, 1, 0, 8'd0, 4);
    applyStimulus(1, 1, 0, 8'd0, 1);
    applyStimulus(0, 0, 0, 8'd0, 2);
    // Zero configuration while running at H=2
    applyStimulus(0, 1, 1, 8'd2, 1);
    applyStimulus(0, 1, 0, 8'd0, 3);
    applyStimulus(0, 1, 1, 8'd0, 1);
    applyStimulus(0, 1, 0, 8'd0, 12);
    // Randomized traffic
    ee = 1;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) ee = !ee;
      vv = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) hh = '0;
      else hh = CNT_W'($urandom_range(1, 6));
      applyStimulus(rr, ee, vv, hh, 1);
    end
    @(posedge clk);
    #2;
    checkCount++;
    if (expQ.size() != 0)
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
    else
      passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
